// File: rtl/reg_rename_file.sv
// Architectural register file with per-register rename tags. Renames come in from issue,
// commits and flushes come from the reorder buffer, and decode sources are looked up here.
module reg_rename_file #(
  parameter int unsigned NREG = 32,
  parameter int unsigned TAGW = 4,
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rdy,
  input  logic            rn_en,
  input  logic [4:0]      rn_rd,
  input  logic [TAGW-1:0] rn_tag,
  input  logic            cm_en,
  input  logic [4:0]      cm_rd,
  input  logic [TAGW-1:0] cm_tag,
  input  logic [XLEN-1:0] cm_val,
  input  logic            flush,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic            rs1_ready,
  output logic [XLEN-1:0] rs1_val,
  output logic            rs2_ready,
  output logic [XLEN-1:0] rs2_val,
  output logic [5:0]      busy_cnt
);

  logic [XLEN-1:0] val_q [NREG];
  logic [XLEN-1:0] val_d [NREG];
  logic [TAGW-1:0] tag_q [NREG];
  logic [TAGW-1:0] tag_d [NREG];
  logic [NREG-1:0] busy_q, busy_d;
  logic [5:0]      cnt_q, cnt_d;

  always_comb begin
    val_d  = val_q;
    tag_d  = tag_q;
    busy_d = busy_q;
    if (rdy) begin
      for (int unsigned i = 1; i < NREG; i++) begin
        if (cm_en && cm_rd == 5'(i)) begin
          val_d[i] = cm_val;
          if (busy_q[i] && tag_q[i] == cm_tag) busy_d[i] = 1'b0;
        end
        // A rename after the commit clear lets the newer tag win on a same-register collision.
        if (rn_en && !flush && rn_rd == 5'(i)) begin
          busy_d[i] = 1'b1;
          tag_d[i]  = rn_tag;
        end
      end
      if (flush) busy_d = '0;
    end
    busy_d[0] = 1'b0;
  end

  always_comb begin
    cnt_d = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      cnt_d = cnt_d + 6'(busy_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      val_q  <= '{default: '0};
      tag_q  <= '{default: '0};
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      val_q  <= val_d;
      tag_q  <= tag_d;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_cnt = cnt_q;

  logic [4:0]      src_addr  [2];
  logic            src_ready [2];
  logic [XLEN-1:0] src_val   [2];

  assign src_addr[0] = rs1_addr;
  assign src_addr[1] = rs2_addr;

  // Lookups see pre-edge state, with a bypass for the commit retiring the current producer.
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      src_ready[s] = 1'b1;
      src_val[s]   = '0;
      if (src_addr[s] != 5'd0) begin
        if (busy_q[src_addr[s]]) begin
          if (cm_en && cm_rd == src_addr[s] && cm_tag == tag_q[src_addr[s]]) begin
            src_val[s] = cm_val;
          end else begin
            src_ready[s] = 1'b0;
            src_val[s]   = XLEN'(tag_q[src_addr[s]]);
          end
        end else begin
          src_val[s] = val_q[src_addr[s]];
        end
      end
    end
  end

  assign rs1_ready = src_ready[0];
  assign rs1_val   = src_val[0];
  assign rs2_ready = src_ready[1];
  assign rs2_val   = src_val[1];

endmodule

// File: doc/reg_rename_file.md
Name: reg_rename_file

Overview:
- Architectural register file with per-register rename status, built for the out-of-order core.
- It is the receiving end of the reorder buffer's register-update interface:
  - rename-at-issue requests tag a destination register with its reorder-buffer index.
  - commit requests write the retired value and release the tag.
- Decode-stage source lookups return either a ready value or the producing reorder tag.
- A flush port drops all outstanding renames on branch misprediction.

Parameters:
- NREG, 32, number of architectural registers; x0 is hardwired to zero.
- TAGW, 4, reorder-buffer index width (16-entry ROB).
- XLEN, 32, data width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- rdy  in  1  global enable; when low, all state holds.
- rn_en  in  1  rename request from issue.
- rn_rd  in  5  destination register being renamed.
- rn_tag  in  TAGW  ROB index of the renaming instruction.
- cm_en  in  1  commit request from ROB.
- cm_rd  in  5  destination register of the committing instruction.
- cm_tag  in  TAGW  ROB index being committed.
- cm_val  in  XLEN  committed value.
- flush  in  1  misprediction flush; clears all rename state.
- rs1_addr  in  5  source 1 lookup address.
- rs2_addr  in  5  source 2 lookup address.
- rs1_ready  out  1  source 1 value is available.
- rs1_val  out  XLEN  value if ready, else the producer tag zero-extended to XLEN.
- rs2_ready  out  1  as rs1_ready, for source 2.
- rs2_val  out  XLEN  as rs1_val, for source 2.
- busy_cnt  out  6  registered count of currently renamed registers.

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is synchronous and active-high.
- State per register: val[XLEN], busy, tag[TAGW].
- Reset: all val=0, busy=0, tag=0, busy_cnt=0. Reset takes precedence over rdy and over every request.
- rdy low: no state update. Lookup outputs remain combinational from current state.
- Lookups are combinational, evaluated against pre-edge state (an instruction reading its own rd sees the old mapping). Per source:
  - addr==0 -> ready=1, val=0.
  - busy and cm_en and cm_rd==addr and cm_tag==tag -> ready=1, val=cm_val (commit bypass).
  - busy otherwise -> ready=0, val={0, tag}.
  - not busy -> ready=1, val=val[addr].
- Commit at posedge (cm_en, rdy, cm_rd!=0):
  - val[cm_rd] <= cm_val unconditionally.
  - busy cleared only if busy and tag==cm_tag, and not re-renamed this cycle.
  - On tag mismatch the reg stays busy under the newer tag.
- Rename at posedge (rn_en, rdy, !flush, rn_rd!=0): busy<=1, tag<=rn_tag.
- Same cycle, same register, rename+commit: rename wins for busy/tag; the value is still written.
- Flush at posedge (rdy):
  - all busy<=0; a rename in the same cycle is dropped.
  - a commit in the same cycle still writes its value.
  - busy_cnt<=0.
- Writes/renames to x0 are ignored; x0 is never busy.
- busy_cnt: next value = population count of the next busy vector, range 0..31, no wrap.
- The block performs no tag-range checking; the ROB guarantees tag uniqueness among in-flight entries.

Test Plan:
- Reset, then read x5 and x0 -> ready=1, val=0 for both; busy_cnt=0.
- Rename x3 tag 7 -> next cycle rs1_addr=3 gives ready=0, val=7; busy_cnt=1.
- Commit x3 tag 7 val 0xDEADBEEF:
  - same-cycle lookup of x3 -> ready=1, val=0xDEADBEEF (bypass).
  - next cycle -> ready=1 from array; busy_cnt=0.
- Rename x4 tag 2, then rename x4 tag 9, then commit x4 tag 2 val 0x11 -> x4 stays busy with tag 9, val[x4]=0x11 internally; lookup gives ready=0, val=9.
- Same cycle: rename x6 tag 5, commit x6 tag 1 val 0x22 (x6 previously busy tag 1) -> x6 busy tag 5; after commit tag 5 val 0x33, x6 reads 0x33.
- Rename x1, x2, x8 (tags 1, 2, 3), then flush together with rename x9 tag 4 and commit x2 tag 2 val 0x44:
  - x1, x2, x8, x9 all ready; x2 reads 0x44; busy_cnt=0.
  - rdy low during any request -> no state change.
